// File: rtl/sar_search_ctrl_pkg.sv
// Shared encodings for the SAR search controller: FSM states and one-hot
// {gt,eq,lt} comparator result codes.
package sar_search_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Probe/result channel between the search controller (master) and a
// magnitude comparator holding the target (slave).
interface sar_search_ctrl_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] probe;
  logic             probe_valid;
  logic             cmp_valid;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;

  modport master (output probe, probe_valid,
                  input  cmp_valid, cmp_gt, cmp_eq, cmp_lt);
  modport slave  (input  probe, probe_valid,
                  output cmp_valid, cmp_gt, cmp_eq, cmp_lt);
endinterface

// File: rtl/sar_search_ctrl_cmp_result_decode.sv
// Classifies a {gt,eq,lt} comparator answer; anything not exactly one-hot
// is flagged as bad.
module cmp_result_decode
  import sar_search_ctrl_pkg::*;
(
  input  logic [2:0] code,
  output logic       is_gt,
  output logic       is_eq,
  output logic       is_lt,
  output logic       is_bad
);

  assign is_gt  = (code == RES_GT);
  assign is_eq  = (code == RES_EQ);
  assign is_lt  = (code == RES_LT);
  assign is_bad = !(is_gt || is_eq || is_lt);

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: binary-searches the full
// WIDTH-bit range using a three-way comparator behind sar_search_ctrl_if.
//
// state | meaning
// IDLE  | waiting for start; search results held
// PROBE | probe presented, waiting for a comparator result
// DONE  | one-cycle done pulse, then back to IDLE
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  sar_search_ctrl_if.master    cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic [CW-1:0]        probe_count
);

  state_t           state, state_nxt;
  logic [WIDTH:0]   lo, hi, lo_nxt, hi_nxt;
  logic [WIDTH:0]   probe_inc, probe_dec;
  logic [WIDTH-1:0] probe_w, result_nxt;
  logic [CW-1:0]    count_nxt;
  logic             found_nxt, err_nxt;
  logic             is_gt, is_eq, is_lt, is_bad;

  // lo+hi never exceeds 2*(2**WIDTH-1) while probing, so WIDTH+1 bits suffice.
  assign probe_w   = WIDTH'((lo + hi) >> 1);
  assign probe_inc = {1'b0, probe_w} + (WIDTH+1)'(1);
  assign probe_dec = {1'b0, probe_w} - (WIDTH+1)'(1);

  cmp_result_decode u_decode (
    .code   ({cmp.cmp_gt, cmp.cmp_eq, cmp.cmp_lt}),
    .is_gt  (is_gt),
    .is_eq  (is_eq),
    .is_lt  (is_lt),
    .is_bad (is_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lo          <= '0;
      hi          <= '0;
      found       <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      probe_count <= '0;
    end else begin
      state       <= state_nxt;
      lo          <= lo_nxt;
      hi          <= hi_nxt;
      found       <= found_nxt;
      err         <= err_nxt;
      result      <= result_nxt;
      probe_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lo_nxt     = lo;
    hi_nxt     = hi;
    found_nxt  = found;
    err_nxt    = err;
    result_nxt = result;
    count_nxt  = probe_count;
    case (state)
      ST_IDLE: begin
        if (start) begin
          lo_nxt    = '0;
          hi_nxt    = {1'b0, {WIDTH{1'b1}}};
          count_nxt = '0;
          found_nxt = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (cmp.cmp_valid) begin
          count_nxt  = probe_count + CW'(1);
          result_nxt = probe_w;
          if (is_eq) begin
            found_nxt = 1'b1;
            state_nxt = ST_DONE;
          end else if (is_gt) begin
            lo_nxt = probe_inc;
            if (probe_inc > hi) state_nxt = ST_DONE;
          end else if (is_lt) begin
            hi_nxt = probe_dec;
            // guard bit set means probe was 0: range exhausted below
            if (probe_dec[WIDTH] || (lo > probe_dec)) state_nxt = ST_DONE;
          end else if (is_bad) begin
            err_nxt   = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmp.probe       = probe_w;
  assign cmp.probe_valid = (state == ST_PROBE);
  assign busy            = (state == ST_PROBE);
  assign done            = (state == ST_DONE);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: a behavioural comparator answers probes,
// expected probes/outcomes are queued at start and popped as the DUT responds.
module tb_sar_search_ctrl;
  import sar_search_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 2);

  localparam int M_TARGET  = 0;
  localparam int M_ALL_GT  = 1;
  localparam int M_BAD     = 2;
  localparam int M_ALL_LT  = 3;

  typedef struct packed {
    logic          f;
    logic          e;
    logic [7:0]    r;
    logic [CW-1:0] c;
  } outcome_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, found, err;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    probe_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  outcome_t   out_q[$];

  sar_search_ctrl_if #(.WIDTH(WIDTH)) cmp ();

  sar_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cmp         (cmp),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .err         (err),
    .result      (result),
    .probe_count (probe_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},        32'(busy), 0);
    check({tag, "_done"},        32'(done), 0);
    check({tag, "_probe_valid"}, 32'(cmp.probe_valid), 0);
    check({tag, "_probe"},       32'(cmp.probe), 0);
    check({tag, "_found"},       32'(found), 0);
    check({tag, "_err"},         32'(err), 0);
    check({tag, "_result"},      32'(result), 0);
    check({tag, "_count"},       32'(probe_count), 0);
  endtask

  // Runs one search; abort_at > 0 drops rst_n while that probe is presented.
  task automatic run_search(input int mode, input logic [7:0] target, input int bad_at,
                            input int max_stall, input int abort_at, input bit start_in_done);
    int         n;
    int         guard;
    int         stall;
    logic [7:0] held;
    logic [7:0] expp;
    outcome_t   o;
    n = 0;
    guard = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_latency", 32'(cmp.probe_valid), 1);
    while (!done && guard < 200) begin
      guard++;
      if (cmp.probe_valid) begin
        stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
        held = cmp.probe;
        for (int s = 0; s < stall; s++) begin
          cmp.cmp_valid = 1'b0;
          start = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          start = 1'b0;
          check("stall_probe", 32'(cmp.probe), 32'(held));
          check("stall_valid", 32'(cmp.probe_valid), 1);
        end
        if (abort_at > 0 && n == abort_at - 1) begin
          #2 rst_n = 1'b0;
          #1;
          check_reset_values("abort");
          @(posedge clk); #1;
          check("abort_no_done", 32'(done), 0);
          rst_n = 1'b1;
          @(posedge clk); #1;
          check("abort_idle_done", 32'(done), 0);
          check("abort_idle_busy", 32'(busy), 0);
          exp_q.delete();
          if (out_q.size() > 0) o = out_q.pop_front();
          return;
        end
        if (exp_q.size() == 0) begin
          check("probe_queue_empty", 32'(cmp.probe), 32'hFFFF);
          expp = 8'h00;
        end else begin
          expp = exp_q.pop_front();
          check("probe", 32'(cmp.probe), 32'(expp));
        end
        n++;
        case (mode)
          M_ALL_GT: {cmp.cmp_gt, cmp.cmp_eq, cmp.cmp_lt} = RES_GT;
          M_ALL_LT: {cmp.cmp_gt, cmp.cmp_eq, cmp.cmp_lt} = RES_LT;
          default: begin
            cmp.cmp_gt = (target > cmp.probe);
            cmp.cmp_eq = (target == cmp.probe);
            cmp.cmp_lt = (target < cmp.probe);
            if (mode == M_BAD && n == bad_at) {cmp.cmp_gt, cmp.cmp_eq, cmp.cmp_lt} = 3'b110;
          end
        endcase
        cmp.cmp_valid = 1'b1;
        @(posedge clk); #1;
        cmp.cmp_valid = 1'b0;
        {cmp.cmp_gt, cmp.cmp_eq, cmp.cmp_lt} = 3'b000;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("done_seen", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_probe_valid", 32'(cmp.probe_valid), 0);
    check("leftover_probes", 32'(exp_q.size()), 0);
    exp_q.delete();
    if (out_q.size() == 0) begin
      check("outcome_queue_empty", 0, 1);
    end else begin
      o = out_q.pop_front();
      check("found",       32'(found), 32'(o.f));
      check("err",         32'(err), 32'(o.e));
      check("result",      32'(result), 32'(o.r));
      check("probe_count", 32'(probe_count), 32'(o.c));
    end
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_probe_valid", 32'(cmp.probe_valid), 0);
    check("hold_found", 32'(found), 32'(o.f));
    check("hold_count", 32'(probe_count), 32'(o.c));
  endtask

  initial begin
    cmp.cmp_valid = 1'b0;
    cmp.cmp_gt = 1'b0;
    cmp.cmp_eq = 1'b0;
    cmp.cmp_lt = 1'b0;
    #1;
    check_reset_values("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. target 0x5A, zero-wait, start during DONE must be ignored
    exp_q = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h5B, 8'h59, 8'h5A};
    out_q.push_back('{f: 1'b1, e: 1'b0, r: 8'h5A, c: CW'(8)});
    run_search(M_TARGET, 8'h5A, 0, 0, 0, 1'b1);

    // 2. range extremes
    exp_q = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    out_q.push_back('{f: 1'b1, e: 1'b0, r: 8'h00, c: CW'(8)});
    run_search(M_TARGET, 8'h00, 0, 0, 0, 1'b0);
    exp_q = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
    out_q.push_back('{f: 1'b1, e: 1'b0, r: 8'hFF, c: CW'(9)});
    run_search(M_TARGET, 8'hFF, 0, 0, 0, 1'b0);

    // 3. always gt: lo overflows past 0xFF
    exp_q = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
    out_q.push_back('{f: 1'b0, e: 1'b0, r: 8'hFF, c: CW'(9)});
    run_search(M_ALL_GT, 8'h00, 0, 0, 0, 1'b0);

    // always lt: hi underflows below 0
    exp_q = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    out_q.push_back('{f: 1'b0, e: 1'b0, r: 8'h00, c: CW'(8)});
    run_search(M_ALL_LT, 8'h00, 0, 0, 0, 1'b0);

    // 4. non-one-hot answer on the 3rd probe
    exp_q = '{8'h7F, 8'h3F, 8'h5F};
    out_q.push_back('{f: 1'b0, e: 1'b1, r: 8'h5F, c: CW'(3)});
    run_search(M_BAD, 8'h5A, 3, 0, 0, 1'b0);

    // 5. random stalls with stray start pulses
    exp_q = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h5B, 8'h59, 8'h5A};
    out_q.push_back('{f: 1'b1, e: 1'b0, r: 8'h5A, c: CW'(8)});
    run_search(M_TARGET, 8'h5A, 0, 5, 0, 1'b0);

    // 6. reset during the 4th probe, then a clean repeat of scenario 1
    exp_q = '{8'h7F, 8'h3F, 8'h5F, 8'h4F};
    out_q.push_back('{f: 1'b1, e: 1'b0, r: 8'h5A, c: CW'(8)});
    run_search(M_TARGET, 8'h5A, 0, 0, 4, 1'b0);
    exp_q = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h5B, 8'h59, 8'h5A};
    out_q.push_back('{f: 1'b1, e: 1'b0, r: 8'h5A, c: CW'(8)});
    run_search(M_TARGET, 8'h5A, 0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
